pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register: the generic successor of the fixed ID/EX latch. Reusable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a control field, a data payload and a valid bit through STAGES chained register slices.
- Adds a global stall (hold), a flush (bubble insertion) and bubble gating of invalid inputs.
- Provides an occupancy counter consumed by the hazard unit.

Parameters:
- CTRL_W, 9, control-field width (WB/M/EX bits, e.g. RegWrite..ALUOp).
- DATA_W, 138, payload width (pc, RS data, RT data, sign-extended imm, rt, rd).
- STAGES, 1, number of chained slices; legal range 1..8; elaboration error outside that range.
- BUBBLE_CTRL, 0 (CTRL_W bits), control value a bubble carries.
- CLEAR_DATA, 1, 1 = bubbles load zero payload; 0 = bubbles load data_i.

Ports:
- clk_i  in  1  clock, rising edge
- start_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold every slice
- flush_i  in  1  load a bubble into slice 0; overrides stall_i
- valid_i  in  1  input entry is real
- ctrl_i  in  CTRL_W  input control field
- data_i  in  DATA_W  input payload
- valid_o  out  1  valid of last slice
- ctrl_o  out  CTRL_W  control of last slice
- data_o  out  DATA_W  payload of last slice
- occ_o  out  $clog2(STAGES+1)  count of valid slices

Behaviour:
- Reset (start_i low, asynchronous, immediate on assertion; released synchronously by the next posedge with start_i high):
  - every slice: valid=0, ctrl=BUBBLE_CTRL, data=0.
  - occ_o=0.
- All state updates on posedge clk_i. Outputs are registered only; there is no combinational path from the inputs.
- Per-cycle mode, in priority order:
  1. flush_i=1: advance. Slice k takes slice k-1 for k>=1. Slice 0 takes a bubble: valid=0, ctrl=BUBBLE_CTRL, data=0 if CLEAR_DATA else data_i. stall_i is ignored.
  2. stall_i=1: hold. Every slice keeps its value, including valid.
  3. Otherwise: advance. Slice 0 captures the input.
     - valid_i=1: slice 0 = {1, ctrl_i, data_i}.
     - valid_i=0: slice 0 is a bubble, formed as in mode 1.
- Latency: an entry accepted at edge n appears on the outputs after edge n+STAGES-1 (visible in cycle n+STAGES-1), provided no stall intervenes. Each stalled cycle adds one cycle.
- The last slice's contents are overwritten on advance. There is no back-pressure or output handshake: the consumer must sample while valid_o=1.
- occ_o equals the popcount of the slice valid bits and is kept as a registered counter:
  - +1 when a valid entry enters slice 0 and the last slice is invalid or not being shifted out.
  - -1 when a valid entry leaves the last slice and slice 0 receives a bubble.
  - unchanged on hold, or when one enters and one leaves in the same cycle.
  - Never exceeds STAGES and never wraps.
- Reset mid-operation discards all entries; occ_o returns to 0 with no partial state.
- STAGES=1: a single slice, behaviourally identical to a plain ID/EX latch with stall/flush added.
- X on ctrl_i/data_i while valid_i=0 must not propagate when CLEAR_DATA=1.

Decomposition:
- Shared package pipe_pkg holds:
  - control-bit index constants (REGWRITE, MEMTOREG, BRANCH, MEMREAD, MEMWRITE, REGDST, ALUSRC, ALUOP_LSB/MSB).
  - default CTRL_W/DATA_W values.
  - the BUBBLE_CTRL default.
  - the payload field offsets.
- One natural sub-module: pipe_stage_slice. It is one register slice (valid/ctrl/data) with hold/load/bubble selects. Instantiate it STAGES times in a generate loop; the top level owns the mode decode and the occ counter.

Test Plan:
- Reset: pulse start_i low mid-cycle with STAGES=3 full -> outputs immediately valid_o=0, ctrl_o=0, data_o=0, occ_o=0, with no clock edge required.
- Streaming, STAGES=3: inject valid ctrl=9'h1A5, data=138'h..C0FFEE, then 9'h042 on consecutive cycles -> 9'h1A5 visible in cycle 2, 9'h042 in cycle 3; occ_o ramps 1,2,2.
- Stall: STAGES=2, hold stall_i=1 for 4 cycles with slice values A,B -> outputs frozen at B, occ_o=2. Deassert -> A emerges on the next edge.
- Flush with stall: stall_i=1, flush_i=1, valid_i=1, ctrl_i=9'h1FF, STAGES=1 -> next cycle valid_o=0, ctrl_o=BUBBLE_CTRL, data_o=0, occ_o=0.
- Invalid input gating: valid_i=0, ctrl_i=9'h1FF, data_i=X, CLEAR_DATA=1 -> ctrl_o=0, data_o=0, no X on any output.
- Occupancy boundary: STAGES=4, 10 back-to-back valid entries -> occ_o saturates at exactly 4. Then 4 bubbles -> occ_o steps 3,2,1,0, with no underflow on further bubbles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bit map, payload layout, defaults.
// Imported by every inter-stage register file.
package pipe_pkg;

    localparam int CTRL_W_DEF = 9;
    localparam int DATA_W_DEF = 138;

    localparam int REGWRITE  = 8;
    localparam int MEMTOREG  = 7;
    localparam int BRANCH    = 6;
    localparam int MEMREAD   = 5;
    localparam int MEMWRITE  = 4;
    localparam int REGDST    = 3;
    localparam int ALUSRC    = 2;
    localparam int ALUOP_MSB = 1;
    localparam int ALUOP_LSB = 0;

    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = '0;

    // payload: {pc, rs_data, rt_data, imm, rt, rd}
    localparam int RD_LSB      = 0;
    localparam int RT_LSB      = 5;
    localparam int IMM_LSB     = 10;
    localparam int RT_DATA_LSB = 42;
    localparam int RS_DATA_LSB = 74;
    localparam int PC_LSB      = 106;

    typedef enum logic [1:0] {
        MODE_LOAD,
        MODE_BUBBLE,
        MODE_HOLD,
        MODE_FLUSH
    } mode_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Entry bus into and out of an inter-stage register.
// slave = the register itself, master = the surrounding stage logic.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int DATA_W = pipe_pkg::DATA_W_DEF
) ();

    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;

    modport slave (
        input  valid_i, ctrl_i, data_i,
        output valid_o, ctrl_o, data_o
    );

    modport master (
        output valid_i, ctrl_i, data_i,
        input  valid_o, ctrl_o, data_o
    );

endinterface

// File: rtl/pipe_stage_reg_slice.sv
// One register slice of the inter-stage register: valid/ctrl/data
// with hold, load and bubble selection.
module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= BUBBLE_CTRL;
            data_o  <= '0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                valid_o <= 1'b0;
                ctrl_o  <= BUBBLE_CTRL;
                data_o  <= CLEAR_DATA ? '0 : data_i;
            end else begin
                valid_o <= valid_i;
                ctrl_o  <= ctrl_i;
                data_o  <= data_i;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES chained slices
// with stall, flush, bubble gating and an occupancy count.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STAGES = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         start_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    pipe_stage_reg_if.slave              bus,
    output logic [$clog2(STAGES+1)-1:0]  occ_o
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be within 1..8");
    end

    mode_e mode;
    logic  hold;
    logic  bubble;
    logic  inc;
    logic  dec;

    logic              v [STAGES+1];
    logic [CTRL_W-1:0] c [STAGES+1];
    logic [DATA_W-1:0] d [STAGES+1];

    // flush outranks stall so a squashed entry never lingers
    always_comb begin
        mode = MODE_BUBBLE;
        priority case (1'b1)
            flush_i:     mode = MODE_FLUSH;
            stall_i:     mode = MODE_HOLD;
            bus.valid_i: mode = MODE_LOAD;
            default:     mode = MODE_BUBBLE;
        endcase
    end

    assign hold   = (mode == MODE_HOLD);
    assign bubble = (mode == MODE_FLUSH) || (mode == MODE_BUBBLE);

    assign v[0] = bus.valid_i;
    assign c[0] = bus.ctrl_i;
    assign d[0] = bus.data_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_stage_slice #(
            .CTRL_W      (CTRL_W),
            .DATA_W      (DATA_W),
            .BUBBLE_CTRL (BUBBLE_CTRL),
            .CLEAR_DATA  (CLEAR_DATA)
        ) u_slice (
            .clk_i    (clk_i),
            .start_i  (start_i),
            .hold_i   (hold),
            .bubble_i ((k == 0) ? bubble : 1'b0),
            .valid_i  (v[k]),
            .ctrl_i   (c[k]),
            .data_i   (d[k]),
            .valid_o  (v[k+1]),
            .ctrl_o   (c[k+1]),
            .data_o   (d[k+1])
        );
    end

    assign bus.valid_o = v[STAGES];
    assign bus.ctrl_o  = c[STAGES];
    assign bus.data_o  = d[STAGES];

    assign inc = (mode == MODE_LOAD);
    assign dec = !hold && v[STAGES];

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            occ_o <= '0;
        end else begin
            unique case ({inc, dec})
                2'b10:   occ_o <= occ_o + OCC_ONE;
                2'b01:   occ_o <= occ_o - OCC_ONE;
                default: occ_o <= occ_o;
            endcase
        end
    end

endmodule
